// File: rtl/reg_scoreboard_pkg.sv
// Shared core definitions for the register scoreboard.
// Architectural register file geometry and register index type.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between the ID stage and the scoreboard.
// The master drives issue and writeback requests; the slave answers with stall and status.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) ();

    logic                     issue_valid;
    reg_idx_t                 issue_rs1;
    reg_idx_t                 issue_rs2;
    logic                     issue_use_rs1;
    logic                     issue_use_rs2;
    reg_idx_t                 issue_rd;
    logic                     issue_regwrite;
    logic                     wb_valid;
    reg_idx_t                 wb_rd;
    logic                     flush;
    logic                     stall;
    logic [NUM_ARCH_REGS-1:0] pending_mask;
    logic [CNT_W-1:0]         outstanding;
    logic                     sb_error;

    modport master (
        output issue_valid, issue_rs1, issue_rs2,
        output issue_use_rs1, issue_use_rs2,
        output issue_rd, issue_regwrite,
        output wb_valid, wb_rd, flush,
        input  stall, pending_mask, outstanding, sb_error
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2,
        input  issue_use_rs1, issue_use_rs2,
        input  issue_rd, issue_regwrite,
        input  wb_valid, wb_rd, flush,
        output stall, pending_mask, outstanding, sb_error
    );

endinterface

// File: rtl/reg_scoreboard_hazard_check.sv
// Read-after-write check of one register against the pending bits,
// with a register retiring this cycle treated as already written.
module sb_hazard_check
    import reg_scoreboard_pkg::*;
(
    input  reg_idx_t                 r,
    input  logic [NUM_ARCH_REGS-1:0] pending_mask,
    input  logic                     wb_valid,
    input  reg_idx_t                 wb_rd,
    output logic                     raw
);

    logic nonzero;
    logic wb_hit;

    assign nonzero = (r != '0);
    assign wb_hit  = wb_valid && (wb_rd == r) && nonzero;
    assign raw     = nonzero && pending_mask[r] && !wb_hit;

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side tracker of in-flight register writes.
// Stalls issue on unresolved RAW/WAW hazards or when the write budget is spent.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic            clk,
    input logic            rst,
    reg_scoreboard_if.slave sb
);

    logic [NUM_ARCH_REGS-1:0] pending_q;
    logic [NUM_ARCH_REGS-1:0] pending_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     err_q;
    logic                     raw_rs1;
    logic                     raw_rs2;
    logic                     raw_rd;
    logic                     wb_dec;
    logic                     wb_miss;
    logic                     full;
    logic                     accept;
    logic                     do_set;
    logic                     stall;

    sb_hazard_check u_rs1 (
        .r            (sb.issue_rs1),
        .pending_mask (pending_q),
        .wb_valid     (sb.wb_valid),
        .wb_rd        (sb.wb_rd),
        .raw          (raw_rs1)
    );

    sb_hazard_check u_rs2 (
        .r            (sb.issue_rs2),
        .pending_mask (pending_q),
        .wb_valid     (sb.wb_valid),
        .wb_rd        (sb.wb_rd),
        .raw          (raw_rs2)
    );

    sb_hazard_check u_rd (
        .r            (sb.issue_rd),
        .pending_mask (pending_q),
        .wb_valid     (sb.wb_valid),
        .wb_rd        (sb.wb_rd),
        .raw          (raw_rd)
    );

    assign wb_dec  = sb.wb_valid && (sb.wb_rd != '0) && pending_q[sb.wb_rd];
    assign wb_miss = sb.wb_valid && (sb.wb_rd != '0) && !pending_q[sb.wb_rd];
    assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));

    // A full budget is acceptable if a tracked write retires this same cycle.
    assign stall = sb.issue_valid && (
        (sb.issue_use_rs1 && raw_rs1) ||
        (sb.issue_use_rs2 && raw_rs2) ||
        (sb.issue_regwrite && raw_rd) ||
        (sb.issue_regwrite && (sb.issue_rd != '0) && full && !wb_dec));

    assign accept = sb.issue_valid && !stall && !sb.flush;
    assign do_set = accept && sb.issue_regwrite && (sb.issue_rd != '0);

    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (sb.flush) begin
            pending_d = '0;
            cnt_d     = '0;
        end else begin
            // Clear before set so a same-register collision stays pending.
            if (wb_dec) pending_d[sb.wb_rd] = 1'b0;
            if (do_set) pending_d[sb.issue_rd] = 1'b1;
            pending_d[0] = 1'b0;
            cnt_d = cnt_q + CNT_W'(do_set) - CNT_W'(wb_dec);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_q | (wb_miss && !sb.flush);
        end
    end

    assign sb.stall        = stall;
    assign sb.pending_mask = pending_q;
    assign sb.outstanding  = cnt_q;
    assign sb.sb_error     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: each cycle's expected
// stall and state are queued by the driver and checked by a monitor.
module tb_reg_scoreboard;

    typedef struct {
        int          id;
        logic        stall;
        logic [31:0] mask;
        logic [2:0]  outs;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_scoreboard_if #(.MAX_OUTSTANDING(4)) sbif ();

    reg_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL step%0d %s: got 0x%0h expected 0x%0h", id, nm, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, one expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "stall", 32'(sbif.stall), 32'(e.stall));
            chk(e.id, "pending_mask", sbif.pending_mask, e.mask);
            chk(e.id, "outstanding", 32'(sbif.outstanding), 32'(e.outs));
            chk(e.id, "sb_error", 32'(sbif.sb_error), 32'(e.err));
        end
    end

    // Drive one cycle of inputs and queue what must be seen mid-cycle.
    task automatic step(
        input logic iv, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd, input logic rw,
        input logic wv, input logic [4:0] wrd, input logic fl,
        input logic es, input logic [31:0] em, input logic [2:0] eo,
        input logic ee);
        exp_t e;
        sbif.issue_valid    = iv;
        sbif.issue_rs1      = rs1;
        sbif.issue_use_rs1  = u1;
        sbif.issue_rs2      = rs2;
        sbif.issue_use_rs2  = u2;
        sbif.issue_rd       = rd;
        sbif.issue_regwrite = rw;
        sbif.wb_valid       = wv;
        sbif.wb_rd          = wrd;
        sbif.flush          = fl;
        step_id++;
        e.id    = step_id;
        e.stall = es;
        e.mask  = em;
        e.outs  = eo;
        e.err   = ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sbif.issue_valid    = 1'b0;
        sbif.issue_rs1      = '0;
        sbif.issue_use_rs1  = 1'b0;
        sbif.issue_rs2      = '0;
        sbif.issue_use_rs2  = 1'b0;
        sbif.issue_rd       = '0;
        sbif.issue_regwrite = 1'b0;
        sbif.wb_valid       = 1'b0;
        sbif.wb_rd          = '0;
        sbif.flush          = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        //   iv rs1 u1 rs2 u2 rd rw wv wrd fl | stall mask outs err
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0, 0);
        // RAW on rd=5, then same-cycle writeback bypass
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 32'h0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   1, 32'h20, 1, 0);
        step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0,   0, 32'h20, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0, 0);
        // unused rs2 ignores hazard; WAW on rd=3
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 32'h0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0,   0, 32'h08, 1, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 32'h08, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 32'h08, 1, 0);
        // budget: fill to 4, then bypass a retiring write
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 32'h02, 1, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 32'h06, 2, 0);
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   0, 32'h0E, 3, 0);
        step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,   1, 32'h1E, 4, 0);
        step(1, 0, 0, 0, 0, 6, 1, 1, 1, 0,   0, 32'h1E, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h5C, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 32'h5C, 4, 0);
        // same-register collision on rd=7
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,   0, 32'h80, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h80, 1, 0);
        // spurious writeback, sticky across flush
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   0, 32'h80, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 32'h80, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0, 1);
        // x0 never tracked, never stalls
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 32'h0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 0,   0, 32'h0, 0, 1);
        // three pending then flush with a competing issue
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 32'h0, 0, 1);
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 32'h02, 1, 1);
        step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,  0, 32'h06, 2, 1);
        step(1, 0, 0, 0, 0, 11, 1, 0, 0, 1,  0, 32'h406, 3, 1);
        step(1, 0, 0, 0, 0, 12, 1, 0, 0, 0,  0, 32'h0, 0, 1);
        step(1, 0, 0, 12, 1, 0, 0, 0, 0, 0,  1, 32'h1000, 1, 1);
        // async reset mid-cycle: zero before the next edge
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
